// File: rtl/trace_buffer.sv
// Commit-trace capture buffer: samples one KLP32V1 trace record per enabled cycle into a
// circular FIFO and drains each record as four 32-bit words over a valid/ready stream.
module trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_capEn,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_inst,
    input  logic [31:0]                i_writeBack,
    input  logic                       i_RegWEn,
    input  logic                       i_memRW,
    input  logic                       i_BrEq,
    input  logic                       i_BrLT,
    output logic                       o_tvalid,
    output logic [31:0]                o_tdata,
    output logic                       o_tlast,
    input  logic                       i_tready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [15:0]                o_dropCount
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] count;
    logic [23:0]   seq;
    logic [1:0]    wi;
    logic          full;
    logic          empty;
    logic          handshake;
    logic          pop;
    logic          push;
    logic [127:0]  head;
    logic [127:0]  newRec;

    // Pointers carry an extra wrap bit so full and empty stay distinct at equal indices.
    assign count     = wrPtr - rdPtr;
    assign full      = (count == PW'(DEPTH));
    assign empty     = (wrPtr == rdPtr);
    assign handshake = !empty && i_tready;
    assign pop       = handshake && (wi == 2'd3);
    assign push      = i_capEn && (!full || pop);
    assign newRec    = {seq, 4'b0000, i_BrLT, i_BrEq, i_memRW, i_RegWEn,
                        i_writeBack, i_inst, i_pc};
    assign head      = mem[rdPtr[AW-1:0]];

    assign o_tvalid = !empty;
    assign o_tlast  = !empty && (wi == 2'd3);
    assign o_count  = count;
    assign o_full   = full;
    assign o_empty  = empty;

    always_comb begin
        o_tdata = '0;
        if (!empty) begin
            case (wi)
                2'd0:    o_tdata = head[31:0];
                2'd1:    o_tdata = head[63:32];
                2'd2:    o_tdata = head[95:64];
                default: o_tdata = head[127:96];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            seq         <= '0;
            wi          <= '0;
            o_dropCount <= '0;
        end else if (i_clear) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            seq         <= '0;
            wi          <= '0;
            o_dropCount <= '0;
        end else begin
            if (i_capEn) begin
                seq <= seq + 24'd1;
                if (!push && (o_dropCount != '1)) begin
                    o_dropCount <= o_dropCount + 16'd1;
                end
            end
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            // wi wraps 3 -> 0 on its own exactly when the head is popped.
            if (handshake) begin
                wi <= wi + 2'd1;
                if (pop) begin
                    rdPtr <= rdPtr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !i_clear) begin
            mem[wrPtr[AW-1:0]] <= newRec;
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: queue-based record model checked every cycle, plus directed
// vectors with hand-computed stream words, sequence numbers and counters.
module tb_trace_buffer;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          i_clear     = 1'b0;
    logic          i_capEn     = 1'b0;
    logic [31:0]   i_pc        = '0;
    logic [31:0]   i_inst      = '0;
    logic [31:0]   i_writeBack = '0;
    logic          i_RegWEn    = 1'b0;
    logic          i_memRW     = 1'b0;
    logic          i_BrEq      = 1'b0;
    logic          i_BrLT      = 1'b0;
    logic          i_tready    = 1'b0;
    logic          o_tvalid;
    logic [31:0]   o_tdata;
    logic          o_tlast;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic [15:0]   o_dropCount;

    int vectors     = 0;
    int miscompares = 0;

    trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (i_clear),
        .i_capEn     (i_capEn),
        .i_pc        (i_pc),
        .i_inst      (i_inst),
        .i_writeBack (i_writeBack),
        .i_RegWEn    (i_RegWEn),
        .i_memRW     (i_memRW),
        .i_BrEq      (i_BrEq),
        .i_BrLT      (i_BrLT),
        .o_tvalid    (o_tvalid),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .i_tready    (i_tready),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_dropCount (o_dropCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of whole records plus how many words of the head were consumed.
    typedef logic [3:0][31:0] rec_t;
    rec_t        mq[$];
    logic [23:0] mSeq  = '0;
    logic [15:0] mDrop = '0;
    int unsigned mWi   = 0;
    logic        mHs, mPop, mPush, mValid;
    rec_t        mRec;

    // Preloads requested by the stimulus when it forces DUT state.
    logic [23:0] seqLoadVal  = '0;
    int          seqLoadCnt  = 0;
    int          seqLoadSeen = 0;
    logic [15:0] dropLoadVal = '0;
    int          dropLoadCnt = 0;
    int          dropLoadSeen = 0;

    always @(posedge clk or posedge reset) begin
        if (seqLoadCnt != seqLoadSeen) begin
            mSeq = seqLoadVal;
            seqLoadSeen = seqLoadCnt;
        end
        if (dropLoadCnt != dropLoadSeen) begin
            mDrop = dropLoadVal;
            dropLoadSeen = dropLoadCnt;
        end
        if (reset || i_clear) begin
            mq.delete();
            mSeq  = '0;
            mDrop = '0;
            mWi   = 0;
        end else begin
            mHs   = (mq.size() != 0) && i_tready;
            mPop  = mHs && (mWi == 3);
            mPush = 1'b0;
            if (i_capEn) begin
                mRec[0] = i_pc;
                mRec[1] = i_inst;
                mRec[2] = i_writeBack;
                mRec[3] = {mSeq, 4'b0000, i_BrLT, i_BrEq, i_memRW, i_RegWEn};
                mSeq = mSeq + 24'd1;
                if (mq.size() < DEPTH || mPop) mPush = 1'b1;
                else if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
            end
            if (mHs) begin
                if (mWi == 3) begin
                    void'(mq.pop_front());
                    mWi = 0;
                end else begin
                    mWi++;
                end
            end
            if (mPush) mq.push_back(mRec);
        end
    end

    always @(negedge clk) begin
        mValid = (mq.size() != 0);
        check("tvalid", 32'(o_tvalid), 32'(mValid));
        if (mValid) check("tdata", o_tdata, mq[0][mWi]);
        check("tlast", 32'(o_tlast), 32'(mValid && (mWi == 3)));
        check("count", 32'(o_count), 32'(mq.size()));
        check("full", 32'(o_full), 32'(mq.size() == DEPTH));
        check("empty", 32'(o_empty), 32'(mq.size() == 0));
        check("dropCount", 32'(o_dropCount), 32'(mDrop));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic setCap(input logic en, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] wb, input logic [3:0] fl);
        i_capEn     = en;
        i_pc        = pc;
        i_inst      = inst;
        i_writeBack = wb;
        {i_BrLT, i_BrEq, i_memRW, i_RegWEn} = fl;
    endtask

    // Drains with tready high and checks the seq field of each word3 against a run.
    task automatic drainSeq(input string name, input int n, input logic [23:0] first);
        int found = 0;
        logic [23:0] e;
        i_tready = 1'b1;
        i_capEn  = 1'b0;
        for (int c = 0; c < n * 4 + 8; c++) begin
            if (o_tvalid && o_tlast) begin
                e = first + 24'(found);
                check(name, 32'(o_tdata[31:8]), 32'(e));
                found++;
            end
            step();
        end
        check({name, "_n"}, 32'(found), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_tdata", o_tdata, 32'd0);
        check("rst_tlast", 32'(o_tlast), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_drop", 32'(o_dropCount), 32'd0);
        reset = 1'b0;

        // Single record, first-word-fall-through.
        i_tready = 1'b1;
        setCap(1'b1, 32'h100, 32'h00500093, 32'h5, 4'b0001);
        step();
        i_capEn = 1'b0;
        check("single_w0", o_tdata, 32'h00000100);
        check("single_v0", 32'(o_tvalid), 32'd1);
        step();
        check("single_w1", o_tdata, 32'h00500093);
        step();
        check("single_w2", o_tdata, 32'h00000005);
        step();
        check("single_w3", o_tdata, 32'h00000001);
        check("single_last", 32'(o_tlast), 32'd1);
        step();
        check("single_done", 32'(o_empty), 32'd1);

        // Backpressure: tready 1,0,0,1,0,0,...; seq is 1 here.
        setCap(1'b1, 32'hA0, 32'h11, 32'h22, 4'b1010);
        i_tready = 1'b0;
        step();
        i_capEn = 1'b0;
        for (int c = 0; c < 16; c++) begin
            i_tready = (c % 3 == 0);
            if (c == 9) begin
                check("bp_w3", o_tdata, 32'h0000010A);
                check("bp_count", 32'(o_count), 32'd1);
            end
            step();
        end
        check("bp_done", 32'(o_empty), 32'd1);

        // Overflow after a clear: 20 captures into a stalled stream.
        i_clear = 1'b1;
        step();
        i_clear  = 1'b0;
        i_tready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            setCap(1'b1, 32'h1000 + k, k, ~k, k[3:0]);
            step();
        end
        i_capEn = 1'b0;
        check("ovf_full", 32'(o_full), 32'd1);
        check("ovf_count", 32'(o_count), 32'd16);
        check("ovf_drop", 32'(o_dropCount), 32'd4);
        drainSeq("ovf_seq", 16, 24'd0);
        setCap(1'b1, 32'h2000, 32'h33, 32'h44, 4'b0100);
        step();
        drainSeq("next_seq", 1, 24'd20);

        // Push and pop on the same edge while full.
        i_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            setCap(1'b1, 32'h3000 + k, 32'h5000 + k, k, 4'b0011);
            step();
        end
        i_capEn = 1'b0;
        check("pp_full", 32'(o_full), 32'd1);
        i_tready = 1'b1;
        step();
        step();
        step();
        check("pp_last", 32'(o_tlast), 32'd1);
        setCap(1'b1, 32'h4000, 32'h66, 32'h77, 4'b1111);
        step();
        i_capEn  = 1'b0;
        i_tready = 1'b0;
        check("pp_count", 32'(o_count), 32'd16);
        check("pp_drop", 32'(o_dropCount), 32'd4);
        drainSeq("pp_seq", 16, 24'd22);

        // Sequence wrap.
        #1;
        force dut.seq = 24'hFFFFFE;
        #1;
        release dut.seq;
        seqLoadVal = 24'hFFFFFE;
        seqLoadCnt++;
        i_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setCap(1'b1, 32'h6000 + k, 32'h7000 + k, k, 4'b0000);
            step();
        end
        drainSeq("wrap_seq", 3, 24'hFFFFFE);

        // Drop counter saturation.
        #1;
        force dut.o_dropCount = 16'hFFFF;
        #1;
        release dut.o_dropCount;
        dropLoadVal = 16'hFFFF;
        dropLoadCnt++;
        i_tready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            setCap(1'b1, 32'h8000 + k, k, k, 4'b0001);
            step();
        end
        i_capEn = 1'b0;
        check("sat_drop", 32'(o_dropCount), 32'h0000FFFF);
        check("sat_count", 32'(o_count), 32'd16);

        // Clear mid-record together with a capture.
        i_tready = 1'b1;
        step();
        step();
        i_clear = 1'b1;
        setCap(1'b1, 32'h9999, 32'h1, 32'h2, 4'b0001);
        step();
        i_clear = 1'b0;
        i_capEn = 1'b0;
        check("clr_empty", 32'(o_empty), 32'd1);
        check("clr_tvalid", 32'(o_tvalid), 32'd0);
        check("clr_drop", 32'(o_dropCount), 32'd0);
        setCap(1'b1, 32'hC0DE, 32'h3, 32'h4, 4'b0000);
        step();
        i_capEn = 1'b0;
        check("clr_w0", o_tdata, 32'h0000C0DE);
        drainSeq("clr_seq", 1, 24'd0);

        // Asynchronous reset mid-record.
        setCap(1'b1, 32'hAAAA, 32'h5, 32'h6, 4'b0010);
        step();
        setCap(1'b1, 32'hBBBB, 32'h7, 32'h8, 4'b0100);
        step();
        i_capEn = 1'b0;
        step();
        #2;
        reset = 1'b1;
        step();
        check("rst2_empty", 32'(o_empty), 32'd1);
        check("rst2_tvalid", 32'(o_tvalid), 32'd0);
        check("rst2_drop", 32'(o_dropCount), 32'd0);
        reset = 1'b0;
        setCap(1'b1, 32'hBEEF, 32'h9, 32'hA, 4'b1000);
        step();
        i_capEn = 1'b0;
        check("rst2_w0", o_tdata, 32'h0000BEEF);
        drainSeq("rst2_seq", 1, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
